ps2_xcvr: RTL and testbench

Bidirectional PS/2 line transceiver sitting directly upstream of the PS/2 mouse protocol controller. Debounces the open-drain PS/2 clock/data pair, deserialises device-to-host frames into bytes with a completion flag, and serialises host-to-device commands, including request-to-send inhibit and acknowledge checking. The mouse controller drives `tx_ena`/`tx_cmd` and consumes `ps2_code`/`ps2_code_new`.

---
 rtl/ps2_xcvr_if.sv | 34 +++
 rtl/ps2_xcvr.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_ps2_xcvr.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_xcvr_if.sv
// ----------------------------------------------------------------------------
// ps2_xcvr_if
//
// Command / code bundle between the PS/2 mouse controller (master) and the
// PS/2 line transceiver (slave). The open-drain pins and clock/reset are
// kept as plain ports on the transceiver itself.
//
//   tx_ena       master -> slave  command request, sampled while tx_busy = 0
//   tx_cmd[8:0]  master -> slave  {odd parity, data[7:0]} supplied by caller
//   tx_busy      slave -> master  transmission in progress
//   ack_error    slave -> master  last transmission not acknowledged
//   ps2_code     slave -> master  last received data byte
//   ps2_code_new slave -> master  level, ps2_code holds a finished frame
//   rx_error     slave -> master  last frame had bad start/stop/parity
// ----------------------------------------------------------------------------
interface ps2_xcvr_if;
    logic       tx_ena;
    logic [8:0] tx_cmd;
    logic       tx_busy;
    logic       ack_error;
    logic [7:0] ps2_code;
    logic       ps2_code_new;
    logic       rx_error;

    modport master (
        output tx_ena, tx_cmd,
        input  tx_busy, ack_error, ps2_code, ps2_code_new, rx_error
    );

    modport slave (
        input  tx_ena, tx_cmd,
        output tx_busy, ack_error, ps2_code, ps2_code_new, rx_error
    );
endinterface

// File: rtl/ps2_xcvr.sv
// ----------------------------------------------------------------------------
// ps2_xcvr
//
// Bidirectional PS/2 line transceiver. Synchronises and debounces the
// open-drain clock/data pair, deserialises device-to-host frames into bytes
// and serialises host-to-device commands (request-to-send inhibit, start
// bit, data/parity, stop, acknowledge check).
//
// Parameters
//   clk_freq       system clock in Hz (sets inhibit, idle and timeout counts)
//   debounce_size  debounce counter width, a line change is accepted after
//                  2^debounce_size stable cycles
//
// Ports
//   clock     system clock, rising edge
//   reset     asynchronous, active-low reset
//   bus       ps2_xcvr_if.slave command/code bundle
//   ps2_clk   open-drain PS/2 clock, driven 0 or Z only
//   ps2_data  open-drain PS/2 data, driven 0 or Z only
//
// Build option
//   PS2_TX_TIMEOUT_EN  when defined, a clk_freq/50 cycle (20 ms) watchdog
//                      runs from START until RELEASE exits; on expiry both
//                      lines are released, ack_error is set and the
//                      transceiver returns to IDLE. When undefined a silent
//                      device leaves tx_busy high until reset.
// ----------------------------------------------------------------------------
module ps2_xcvr #(
    parameter int clk_freq      = 50_000_000,
    parameter int debounce_size = 8
) (
    input  logic      clock,
    input  logic      reset,
    ps2_xcvr_if.slave bus,
    inout  wire       ps2_clk,
    inout  wire       ps2_data
);

    localparam int idle_cycles    = clk_freq / 18000;   // ~55 us bus idle
    localparam int inhibit_cycles = clk_freq / 10000;   // 100 us clock hold
    localparam int timer_w        = $clog2(inhibit_cycles + 1);
`ifdef PS2_TX_TIMEOUT_EN
    localparam int timeout_cycles = clk_freq / 50;      // 20 ms watchdog
    localparam int wdog_w         = $clog2(timeout_cycles + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_INHIBIT,
        S_START,
        S_TX,
        S_ACK,
        S_RELEASE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and debounce, bit 0 = clock line, bit 1 = data
    // ------------------------------------------------------------------
    logic [1:0]               pin;
    logic [1:0]               sync0;
    logic [1:0]               sync1;
    logic [1:0]               deb;
    logic [debounce_size-1:0] deb_cnt [2];

    assign pin = {ps2_data, ps2_clk};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // Idle bus is high, so the filters start there to avoid a
            // phantom falling edge right after reset.
            sync0 <= 2'b11;
            sync1 <= 2'b11;
            deb   <= 2'b11;
            // NOTE: the counter array is tiny and feeds control decisions,
            // so it is reset like any other register rather than left as
            // an uninitialised memory.
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync0 <= pin;
            sync1 <= sync0;
            for (int i = 0; i < 2; i++) begin
                if (sync1[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == '1) begin
                    // 2^debounce_size consecutive cycles at the new level
                    deb[i]     <= sync1[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic dclk;
    logic ddat;
    logic dclk_prev;
    logic fall;

    assign dclk = deb[0];
    assign ddat = deb[1];
    assign fall = dclk_prev & ~dclk;

    // ------------------------------------------------------------------
    // Main state machine and datapath registers
    // ------------------------------------------------------------------
    state_t               state,    state_nxt;
    logic [3:0]           bit_cnt,  bit_cnt_nxt;
    logic [timer_w-1:0]   timer,    timer_nxt;
    logic [10:0]          rx_shift, rx_shift_nxt;
    logic [8:0]           tx_bits,  tx_bits_nxt;
    logic                 clk_low,  clk_low_nxt;
    logic                 data_low, data_low_nxt;
    logic                 busy,     busy_nxt;
    logic                 ack_err,  ack_err_nxt;
    logic [7:0]           code,     code_nxt;
    logic                 code_new, code_new_nxt;
    logic                 rx_err,   rx_err_nxt;
    logic [10:0]          frame_next;
`ifdef PS2_TX_TIMEOUT_EN
    logic [wdog_w-1:0]    wdog,     wdog_nxt;
`endif

    // Frame after shifting in the current data bit, LSB (start) first.
    assign frame_next = {ddat, rx_shift[10:1]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            timer     <= '0;
            rx_shift  <= '0;
            tx_bits   <= '0;
            clk_low   <= 1'b0;
            data_low  <= 1'b0;
            busy      <= 1'b0;
            ack_err   <= 1'b0;
            code      <= '0;
            code_new  <= 1'b0;
            rx_err    <= 1'b0;
            dclk_prev <= 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
            wdog      <= '0;
`endif
        end else begin
            // NOTE: every register here updates with <= so all of them see
            // the pre-edge values computed by the combinational block.
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            timer     <= timer_nxt;
            rx_shift  <= rx_shift_nxt;
            tx_bits   <= tx_bits_nxt;
            clk_low   <= clk_low_nxt;
            data_low  <= data_low_nxt;
            busy      <= busy_nxt;
            ack_err   <= ack_err_nxt;
            code      <= code_nxt;
            code_new  <= code_new_nxt;
            rx_err    <= rx_err_nxt;
            dclk_prev <= dclk;
`ifdef PS2_TX_TIMEOUT_EN
            wdog      <= wdog_nxt;
`endif
        end
    end

    always_comb begin
        // NOTE: every value produced here starts from its held value so no
        // path through the case statement can leave a latch behind.
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        timer_nxt    = timer;
        rx_shift_nxt = rx_shift;
        tx_bits_nxt  = tx_bits;
        clk_low_nxt  = clk_low;
        data_low_nxt = data_low;
        busy_nxt     = busy;
        ack_err_nxt  = ack_err;
        code_nxt     = code;
        code_new_nxt = code_new;
        rx_err_nxt   = rx_err;
`ifdef PS2_TX_TIMEOUT_EN
        wdog_nxt     = wdog;
`endif

        case (state)
            S_IDLE, S_RX: begin
                if (bus.tx_ena) begin
                    // A command request wins over (and aborts) reception.
                    state_nxt    = S_INHIBIT;
                    busy_nxt     = 1'b1;
                    tx_bits_nxt  = bus.tx_cmd;
                    code_new_nxt = 1'b0;
                    clk_low_nxt  = 1'b1;
                    timer_nxt    = '0;
                end else if (fall) begin
                    // The edge that leaves IDLE, or that interrupts the
                    // idle wait, is the start bit of a fresh frame.
                    state_nxt    = S_RX;
                    rx_shift_nxt = frame_next;
                    timer_nxt    = '0;
                    code_new_nxt = 1'b0;
                    if (state == S_RX && bit_cnt != 4'd11) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd10) begin
                            code_nxt   = frame_next[8:1];
                            rx_err_nxt = frame_next[0] | ~frame_next[10] |
                                         ~(^frame_next[9:1]);
                        end
                    end else begin
                        bit_cnt_nxt = 4'd1;
                    end
                end else if (state == S_RX && bit_cnt == 4'd11 && dclk) begin
                    // Frame complete, wait for the bus to stay idle.
                    if (timer == timer_w'(idle_cycles - 1)) begin
                        state_nxt    = S_IDLE;
                        code_new_nxt = 1'b1;
                        timer_nxt    = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
            end

            S_INHIBIT: begin
                if (timer == timer_w'(inhibit_cycles - 1)) begin
                    // Request-to-send: data low and clock released together.
                    state_nxt    = S_START;
                    timer_nxt    = '0;
                    clk_low_nxt  = 1'b0;
                    data_low_nxt = 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
                    wdog_nxt     = '0;
`endif
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end

            S_START: begin
                state_nxt   = S_TX;
                bit_cnt_nxt = '0;
            end

            S_TX: begin
                if (fall) begin
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        // Tenth edge: release data for the stop bit.
                        data_low_nxt = 1'b0;
                        state_nxt    = S_ACK;
                    end else begin
                        data_low_nxt = ~tx_bits[bit_cnt];
                    end
                end
            end

            S_ACK: begin
                if (fall) begin
                    ack_err_nxt = ddat;
                    state_nxt   = S_RELEASE;
                end
            end

            S_RELEASE: begin
                if (dclk && ddat) begin
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                end
            end

            default: begin
                state_nxt    = S_IDLE;
                clk_low_nxt  = 1'b0;
                data_low_nxt = 1'b0;
                busy_nxt     = 1'b0;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog covers a device that never clocks or never releases.
        if (state inside {S_START, S_TX, S_ACK, S_RELEASE}) begin
            if (wdog == wdog_w'(timeout_cycles - 1)) begin
                state_nxt    = S_IDLE;
                clk_low_nxt  = 1'b0;
                data_low_nxt = 1'b0;
                ack_err_nxt  = 1'b1;
                busy_nxt     = 1'b0;
                wdog_nxt     = '0;
            end else begin
                wdog_nxt = wdog + 1'b1;
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Open-drain pin drivers and outputs
    // ------------------------------------------------------------------
    assign ps2_clk  = clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = data_low ? 1'b0 : 1'bz;

    assign bus.tx_busy      = busy;
    assign bus.ack_error    = ack_err;
    assign bus.ps2_code     = code;
    assign bus.ps2_code_new = code_new;
    assign bus.rx_error     = rx_err;

endmodule

// File: tb/tb_ps2_xcvr.sv
// ----------------------------------------------------------------------------
// tb_ps2_xcvr
//
// Drives ps2_xcvr through a behavioural PS/2 device on pulled-up
// open-drain lines. Expected codes, error flags and timings come from the
// frame format rules (odd parity, 11-bit frames, idle/inhibit durations).
// ----------------------------------------------------------------------------
module tb_ps2_xcvr;

    localparam int CLK_FREQ = 1_000_000;
    localparam int DEB_SIZE = 2;
    localparam int HALF     = 15;                 // device half clock period
    localparam int IDLE_CYC = CLK_FREQ / 18000;   // 55
    localparam int INH_CYC  = CLK_FREQ / 10000;   // 100
    localparam int TO_CYC   = CLK_FREQ / 50;      // 20000

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    wire  ps2_clk;
    wire  ps2_data;
    pullup (ps2_clk);
    pullup (ps2_data);

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    assign ps2_clk  = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_data = dev_dat_low ? 1'b0 : 1'bz;

    ps2_xcvr_if bus ();

    ps2_xcvr #(
        .clk_freq      (CLK_FREQ),
        .debounce_size (DEB_SIZE)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   new_rises = 0;
    logic new_q     = 1'b0;

    // Count rising edges of the completion flag, sampled away from posedge.
    always @(negedge clock) begin
        if (bus.ps2_code_new === 1'b1 && new_q !== 1'b1) new_rises++;
        new_q = bus.ps2_code_new;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    // ---------------------------------------------------------------- helpers
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Builds an 11-bit frame; good parity makes data+parity odd.
    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit good);
        logic p;
        p = ($countones(d) % 2 == 0);
        if (!good) p = ~p;
        return {1'b1, p, d, 1'b0};
    endfunction

    // Device clocks out the first n bits of a frame, LSB first.
    task automatic dev_bits(input logic [10:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            dev_dat_low = ~frame[i];
            cycles(HALF);
            dev_clk_low = 1'b1;
            cycles(HALF);
            dev_clk_low = 1'b0;
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_new(input int limit, output int n);
        n = 0;
        while (bus.ps2_code_new !== 1'b1 && n < limit) begin
            cycles(1);
            n++;
        end
    endtask

    // Device side of a host-to-device transfer.
    task automatic dev_receive(input logic ack_bit, output logic [8:0] bits,
                               output logic start, output logic stop,
                               output int low_cycles, output bit ok);
        int t;
        ok = 1'b1; bits = '0; start = 1'b1; stop = 1'b0; low_cycles = 0; t = 0;
        while (ps2_clk !== 1'b0 && t < 1000) begin cycles(1); t++; end
        if (t >= 1000) begin ok = 1'b0; return; end
        while (ps2_clk === 1'b0 && low_cycles < 1000) begin cycles(1); low_cycles++; end
        if (low_cycles >= 1000) begin ok = 1'b0; return; end
        start = ps2_data;
        cycles(HALF);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            cycles(HALF);
            if (i < 9) bits[i] = ps2_data;
            else       stop    = ps2_data;
            dev_clk_low = 1'b0;
            cycles(HALF);
        end
        dev_dat_low = ~ack_bit;
        cycles(HALF);
        dev_clk_low = 1'b1;
        cycles(HALF);
        dev_clk_low = 1'b0;
        cycles(HALF);
        dev_dat_low = 1'b0;
    endtask

    // One device-to-host frame plus all checks on code, error and flag timing.
    task automatic rx_and_check(input logic [7:0] data, input bit good, input string tag);
        logic [10:0] frame;
        logic        exp_err;
        int          r0;
        int          n;
        frame   = make_frame(data, good);
        exp_err = !good;
        r0      = new_rises;
        dev_bits(frame, 11);
        n_checks++;
        if (bus.ps2_code !== data) begin
            n_fail++; $display("FAIL %s code: got %h expected %h", tag, bus.ps2_code, data);
        end
        n_checks++;
        if (bus.rx_error !== exp_err) begin
            n_fail++; $display("FAIL %s rx_error: got %b expected %b", tag, bus.rx_error, exp_err);
        end
        n_checks++;
        if (bus.ps2_code_new !== 1'b0) begin
            n_fail++; $display("FAIL %s flag_early: got %b expected 0", tag, bus.ps2_code_new);
        end
        wait_new(300, n);
        n_checks++;
        if (n < IDLE_CYC || n > IDLE_CYC + 20) begin
            n_fail++; $display("FAIL %s flag_latency: got %0d cycles expected %0d..%0d", tag, n, IDLE_CYC, IDLE_CYC + 20);
        end
        cycles(1);
        n_checks++;
        if (new_rises !== r0 + 1) begin
            n_fail++; $display("FAIL %s flag_rises: got %0d expected %0d", tag, new_rises - r0, 1);
        end
    endtask

    // Host command with the device model acknowledging with ack_bit.
    task automatic tx_and_check(input logic [8:0] cmd, input logic ack_bit, input string tag);
        logic [8:0] bits;
        logic       start;
        logic       stop;
        int         low;
        bit         ok;
        int         t;
        int         r0;
        logic [7:0] code0;
        code0 = bus.ps2_code;
        r0    = new_rises;
        fork
            begin
                bus.tx_cmd = cmd;
                bus.tx_ena = 1'b1;
                cycles(1);
                n_checks++;
                if (bus.tx_busy !== 1'b1) begin
                    n_fail++; $display("FAIL %s busy_rise: got %b expected 1", tag, bus.tx_busy);
                end
                bus.tx_ena = 1'b0;
                cycles(20);
                // Second request while busy must be ignored.
                bus.tx_cmd = ~cmd;
                bus.tx_ena = 1'b1;
                cycles(3);
                bus.tx_ena = 1'b0;
            end
            dev_receive(ack_bit, bits, start, stop, low, ok);
        join
        t = 0;
        while (bus.tx_busy !== 1'b0 && t < 200) begin cycles(1); t++; end
        n_checks++;
        if (!ok || t >= 200) begin
            n_fail++; $display("FAIL %s handshake: device_ok %b busy_wait %0d", tag, ok, t);
        end
        n_checks++;
        if (low < INH_CYC || low > INH_CYC + 5) begin
            n_fail++; $display("FAIL %s inhibit_len: got %0d expected %0d..%0d", tag, low, INH_CYC, INH_CYC + 5);
        end
        n_checks++;
        if (start !== 1'b0 || stop !== 1'b1) begin
            n_fail++; $display("FAIL %s start_stop: got %b/%b expected 0/1", tag, start, stop);
        end
        n_checks++;
        if (bits !== cmd) begin
            n_fail++; $display("FAIL %s tx_bits: got %h expected %h", tag, bits, cmd);
        end
        n_checks++;
        if (bus.ack_error !== ack_bit) begin
            n_fail++; $display("FAIL %s ack_error: got %b expected %b", tag, bus.ack_error, ack_bit);
        end
        cycles(2 * IDLE_CYC);
        n_checks++;
        if (bus.ps2_code_new !== 1'b0 || new_rises !== r0 || bus.ps2_code !== code0) begin
            n_fail++; $display("FAIL %s no_rx_from_tx: flag %b rises %0d code %h expected 0 0 %h",
                               tag, bus.ps2_code_new, new_rises - r0, bus.ps2_code, code0);
        end
        n_checks++;
        if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
            n_fail++; $display("FAIL %s lines_idle: got %b%b expected 11", tag, ps2_clk, ps2_data);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        cycles(3);
        n_checks++;
        if (bus.tx_busy !== 1'b0 || bus.ack_error !== 1'b0 || bus.ps2_code !== 8'h00 ||
            bus.ps2_code_new !== 1'b0 || bus.rx_error !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got busy %b ack %b code %h new %b err %b expected all 0",
                               bus.tx_busy, bus.ack_error, bus.ps2_code, bus.ps2_code_new, bus.rx_error);
        end
        reset = 1'b1;
        cycles(10);
        n_checks++;
        if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || bus.ps2_code_new !== 1'b0) begin
            n_fail++; $display("FAIL reset_lines: got %b%b new %b expected 11 new 0", ps2_clk, ps2_data, bus.ps2_code_new);
        end
    endtask

    task automatic test_rx_fa();
        rx_and_check(8'hFA, 1'b1, "rx_fa");
    endtask

    task automatic test_rx_bad_parity();
        rx_and_check(8'hAA, 1'b0, "rx_aa_badpar");
    endtask

    task automatic test_rx_random();
        for (int i = 0; i < 6; i++) begin
            rx_and_check(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), "rx_random");
        end
    endtask

    task automatic test_discard();
        logic [7:0] a;
        logic [7:0] b;
        int         r0;
        a  = 8'($urandom_range(0, 255));
        b  = ~a;
        r0 = new_rises;
        dev_bits(make_frame(a, 1'b1), 11);
        n_checks++;
        if (bus.ps2_code !== a) begin
            n_fail++; $display("FAIL discard_first_code: got %h expected %h", bus.ps2_code, a);
        end
        cycles(10);
        rx_and_check(b, 1'b1, "discard_second");
        n_checks++;
        if (new_rises !== r0 + 1) begin
            n_fail++; $display("FAIL discard_rises: got %0d expected 1", new_rises - r0);
        end
    endtask

    task automatic test_tx_ff();
        tx_and_check(9'h1FF, 1'b0, "tx_1ff");
    endtask

    task automatic test_tx_random();
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        tx_and_check({($countones(d) % 2 == 0), d}, 1'b0, "tx_random");
    endtask

    task automatic test_tx_ack_high();
        tx_and_check(9'h0F4, 1'b1, "tx_0f4_nack");
    endtask

    task automatic test_reset_mid();
        // Reset while idle with a flagged code and a latched ack error.
        rx_and_check(8'h5C, 1'b1, "pre_reset");
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.ps2_code !== 8'h00 || bus.ps2_code_new !== 1'b0 || bus.ack_error !== 1'b0 ||
            bus.tx_busy !== 1'b0 || bus.rx_error !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: got code %h new %b ack %b busy %b err %b expected 00 0 0 0 0",
                               bus.ps2_code, bus.ps2_code_new, bus.ack_error, bus.tx_busy, bus.rx_error);
        end
        cycles(2);
        reset = 1'b1;
        cycles(10);
        // Reset after five received bits.
        dev_bits(make_frame(8'h3B, 1'b1), 5);
        cycles(3);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.ps2_code !== 8'h00 || bus.ps2_code_new !== 1'b0 || bus.tx_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_rx: got code %h new %b busy %b expected 00 0 0",
                               bus.ps2_code, bus.ps2_code_new, bus.tx_busy);
        end
        cycles(2);
        reset = 1'b1;
        cycles(10);
        // Reset while the transceiver holds the clock low.
        bus.tx_cmd = 9'h1AA;
        bus.tx_ena = 1'b1;
        cycles(1);
        bus.tx_ena = 1'b0;
        cycles(10);
        n_checks++;
        if (ps2_clk !== 1'b0) begin
            n_fail++; $display("FAIL inhibit_drive: got clk %b expected 0", ps2_clk);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || bus.tx_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_tx: got lines %b%b busy %b expected 11 0", ps2_clk, ps2_data, bus.tx_busy);
        end
        cycles(2);
        reset = 1'b1;
        cycles(10);
        rx_and_check(8'h00, 1'b1, "post_reset_00");
    endtask

`ifdef PS2_TX_TIMEOUT_EN
    task automatic test_timeout();
        int t;
        bus.tx_cmd = 9'h1F3;
        bus.tx_ena = 1'b1;
        cycles(1);
        bus.tx_ena = 1'b0;
        t = 1;
        while (bus.tx_busy !== 1'b0 && t < TO_CYC + 5000) begin cycles(1); t++; end
        n_checks++;
        if (t < TO_CYC + INH_CYC || t > TO_CYC + INH_CYC + 10) begin
            n_fail++; $display("FAIL timeout_len: got %0d expected %0d..%0d", t, TO_CYC + INH_CYC, TO_CYC + INH_CYC + 10);
        end
        cycles(1);
        n_checks++;
        if (bus.ack_error !== 1'b1 || ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
            n_fail++; $display("FAIL timeout_state: got ack %b lines %b%b expected 1 11", bus.ack_error, ps2_clk, ps2_data);
        end
    endtask
`else
    task automatic test_no_timeout();
        bus.tx_cmd = 9'h1F3;
        bus.tx_ena = 1'b1;
        cycles(1);
        bus.tx_ena = 1'b0;
        cycles(3000);
        n_checks++;
        if (bus.tx_busy !== 1'b1 || ps2_data !== 1'b0) begin
            n_fail++; $display("FAIL silent_device: got busy %b data %b expected 1 0", bus.tx_busy, ps2_data);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.tx_busy !== 1'b0 || ps2_data !== 1'b1) begin
            n_fail++; $display("FAIL silent_reset: got busy %b data %b expected 0 1", bus.tx_busy, ps2_data);
        end
        cycles(2);
        reset = 1'b1;
        cycles(10);
    endtask
`endif

    initial begin
        bus.tx_ena = 1'b0;
        bus.tx_cmd = '0;
        test_reset();
        test_rx_fa();
        test_rx_bad_parity();
        test_rx_random();
        test_discard();
        test_tx_ff();
        test_tx_random();
        test_tx_ack_high();
        test_reset_mid();
`ifdef PS2_TX_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
